// File: rtl/fan_pwm_bank.sv
// fan_pwm_bank: bank of PWM fan channels sharing one period counter.
// Duty changes are applied only at period wrap, either by jump or one-step ramp.
module fan_pwm_bank #(
    parameter int NCH = 4,
    parameter int W   = 8,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           en,
    input  logic [W-1:0]   top,
    input  logic           ramp_en,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [W-1:0]   wr_duty,
    output logic           wr_ack,
    output logic [NCH-1:0] pwm_out,
    output logic [NCH*W-1:0] duty_cur,
    output logic [NCH-1:0] settled,
    output logic           period_end
);

    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

    logic [W-1:0] cnt;
    logic [W-1:0] tgt  [NCH];
    logic [W-1:0] dcur [NCH];
    logic [W-1:0] dnext [NCH];
    logic         wrap;
    logic         ch_ok;

    assign wrap  = en && (cnt >= top);
    assign ch_ok = ({1'b0, wr_ch} < NCH_L);

    // Shared period counter and wrap pulse; disabled bank idles at zero.
    always_ff @(posedge clk) begin
        if (!arst) begin
            cnt        <= '0;
            period_end <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            period_end <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + W'(1);
            period_end <= wrap;
        end
    end

    // Target register file; writes accepted regardless of en.
    always_ff @(posedge clk) begin
        if (!arst) begin
            wr_ack <= 1'b0;
            for (int i = 0; i < NCH; i++) tgt[i] <= '0;
        end else begin
            wr_ack <= wr_en && ch_ok;
            if (wr_en && ch_ok) tgt[wr_ch] <= wr_duty;
        end
    end

    // Next applied duty: jump to target, or move one step toward it.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            dnext[i] = dcur[i];
            if (!ramp_en) begin
                dnext[i] = tgt[i];
            end else if (dcur[i] < tgt[i]) begin
                dnext[i] = dcur[i] + W'(1);
            end else if (dcur[i] > tgt[i]) begin
                dnext[i] = dcur[i] - W'(1);
            end
        end
    end

    // Applied duty only moves at a wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (!arst) begin
            for (int i = 0; i < NCH; i++) dcur[i] <= '0;
        end else if (wrap) begin
            for (int i = 0; i < NCH; i++) dcur[i] <= dnext[i];
        end
    end

    // Registered PWM compare, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (!arst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                pwm_out[i] <= en && (cnt < dcur[i]);
        end
    end

    // Flatten duties and report channels that reached their target.
    always_comb begin
        duty_cur = '0;
        settled  = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_cur[i*W +: W] = dcur[i];
            settled[i]         = (dcur[i] == tgt[i]);
        end
    end

endmodule

// File: tb/tb_fan_pwm_bank.sv
// tb_fan_pwm_bank: directed vectors plus multi-cycle sequences.
// A second NCH=3 instance exercises out-of-range channel writes.
module tb_fan_pwm_bank;

    logic        clk;
    logic        arst;
    logic        en;
    logic [7:0]  top;
    logic        ramp_en;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [7:0]  wr_duty;
    logic        wr_ack;
    logic [3:0]  pwm_out;
    logic [31:0] duty_cur;
    logic [3:0]  settled;
    logic        period_end;
    logic        wr_ack3;
    logic [2:0]  pwm_out3;
    logic [23:0] duty_cur3;
    logic [2:0]  settled3;
    logic        period_end3;

    int checks = 0;
    int errors = 0;

    fan_pwm_bank #(.NCH(4), .W(8)) u_dut (
        .clk(clk), .arst(arst), .en(en), .top(top),
        .ramp_en(ramp_en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .wr_ack(wr_ack), .pwm_out(pwm_out),
        .duty_cur(duty_cur), .settled(settled),
        .period_end(period_end)
    );

    fan_pwm_bank #(.NCH(3), .W(8)) u_dut3 (
        .clk(clk), .arst(arst), .en(en), .top(top),
        .ramp_en(ramp_en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .wr_ack(wr_ack3), .pwm_out(pwm_out3),
        .duty_cur(duty_cur3), .settled(settled3),
        .period_end(period_end3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] d;
        logic       ack;
        logic       ack3;
        logic [3:0] stl;
    } vec_t;

    vec_t vt[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_wrap(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (period_end) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for period_end", name);
        end
    endtask

    logic [9:0] pat0, pat2, pat3, patpe;
    int cnt_pe;
    int n;

    initial begin
        vt[0] = '{1'b1, 2'd0, 8'd3,  1'b1, 1'b1, 4'b1110};
        vt[1] = '{1'b1, 2'd2, 8'd0,  1'b1, 1'b1, 4'b1110};
        vt[2] = '{1'b1, 2'd3, 8'd10, 1'b1, 1'b0, 4'b0110};
        vt[3] = '{1'b0, 2'd1, 8'd7,  1'b0, 1'b0, 4'b0110};
        vt[4] = '{1'b1, 2'd1, 8'd0,  1'b1, 1'b1, 4'b0110};

        arst    = 1'b0;
        en      = 1'b0;
        top     = 8'd9;
        ramp_en = 1'b0;
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_duty = 8'h55;
        step();
        step();
        chk("rst_pwm", pwm_out, 4'h0);
        chk("rst_duty", duty_cur, 32'h0);
        chk("rst_pe", period_end, 1'b0);
        chk("rst_ack", wr_ack, 1'b0);
        chk("rst_settled", settled, 4'hF);

        arst  = 1'b1;
        wr_en = 1'b0;
        step();
        chk("post_rst_settled", settled, 4'hF);
        chk("post_rst_ack", wr_ack, 1'b0);

        for (int v = 0; v < 5; v++) begin
            wr_en   = vt[v].we;
            wr_ch   = vt[v].ch;
            wr_duty = vt[v].d;
            step();
            chk($sformatf("vec%0d_ack", v), wr_ack, vt[v].ack);
            chk($sformatf("vec%0d_ack3", v), wr_ack3, vt[v].ack3);
            chk($sformatf("vec%0d_settled", v), settled, vt[v].stl);
            chk($sformatf("vec%0d_pwm", v), pwm_out, 4'h0);
            chk($sformatf("vec%0d_pe", v), period_end, 1'b0);
        end
        wr_en = 1'b0;

        en = 1'b1;
        wait_wrap("first_wrap");
        chk("jump_duty0", duty_cur[7:0], 8'd3);
        chk("jump_duty3", duty_cur[31:24], 8'd10);
        for (int k = 0; k < 10; k++) begin
            step();
            pat0[k]  = pwm_out[0];
            pat2[k]  = pwm_out[2];
            pat3[k]  = pwm_out[3];
            patpe[k] = period_end;
        end
        chk("pwm0_pattern", pat0, 10'b0000000111);
        chk("pwm2_zero", pat2, 10'b0000000000);
        chk("pwm3_full", pat3, 10'b1111111111);
        chk("pe_pattern", patpe, 10'b1000000000);

        ramp_en = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd1;
        wr_duty = 8'd5;
        step();
        chk("ramp_wr_ack", wr_ack, 1'b1);
        wr_en = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            wait_wrap($sformatf("ramp_up%0d", s));
            chk($sformatf("ramp_up%0d", s), duty_cur[15:8], 8'(s));
            if (s == 4) chk("settled1_low", settled[1], 1'b0);
        end
        chk("settled1_high", settled[1], 1'b1);
        chk("ramp_hold3", duty_cur[31:24], 8'd10);

        wr_en   = 1'b1;
        wr_ch   = 2'd1;
        wr_duty = 8'd2;
        step();
        wr_en = 1'b0;
        for (int s = 4; s >= 2; s--) begin
            wait_wrap($sformatf("ramp_dn%0d", s));
            chk($sformatf("ramp_dn%0d", s), duty_cur[15:8], 8'(s));
        end

        ramp_en = 1'b0;
        for (int k = 0; k < 9; k++) step();
        wr_en   = 1'b1;
        wr_ch   = 2'd3;
        wr_duty = 8'd6;
        step();
        wr_en = 1'b0;
        chk("wrapcyc_pe", period_end, 1'b1);
        chk("wrapcyc_ack", wr_ack, 1'b1);
        chk("wrapcyc_ack3", wr_ack3, 1'b0);
        chk("wrapcyc_duty3_old", duty_cur[31:24], 8'd10);
        wait_wrap("wrapcyc_next");
        chk("wrapcyc_duty3_new", duty_cur[31:24], 8'd6);
        chk("wrapcyc_settled", settled, 4'hF);

        top    = 8'd200;
        cnt_pe = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (period_end) cnt_pe++;
        end
        chk("long_no_pe", cnt_pe, 0);
        top = 8'd9;
        step();
        chk("lower_top_pe", period_end, 1'b1);
        cnt_pe = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (period_end) cnt_pe++;
        end
        chk("lower_top_gap", cnt_pe, 0);
        step();
        chk("lower_top_resume", period_end, 1'b1);

        top    = 8'd0;
        cnt_pe = 0;
        pat0   = '0;
        pat2   = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (period_end) cnt_pe++;
            pat0[k] = pwm_out[0];
            pat2[k] = pwm_out[2];
        end
        chk("top0_pe", cnt_pe, 5);
        chk("top0_pwm0_high", pat0[4:0], 5'b11111);
        chk("top0_pwm2_low", pat2[4:0], 5'b00000);

        top = 8'd9;
        for (int k = 0; k < 4; k++) step();
        arst  = 1'b0;
        wr_en = 1'b1;
        wr_ch = 2'd2;
        wr_duty = 8'd9;
        step();
        chk("midrst_pe", period_end, 1'b0);
        chk("midrst_pwm", pwm_out, 4'h0);
        chk("midrst_duty", duty_cur, 32'h0);
        chk("midrst_ack", wr_ack, 1'b0);
        chk("midrst_settled", settled, 4'hF);
        arst  = 1'b1;
        wr_en = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            n++;
            if (period_end) break;
        end
        chk("restart_period", n, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
